dice_turn_controller: RTL

//  Game-side consumer of the colour-result interface (stable_color/result_ready/turn_end/current_state_white).

---
 rtl/dice_game_pkg.sv | 30 +++
 rtl/dice_step_sequencer.sv | 50 +++++
 rtl/dice_turn_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dice_game_pkg.sv
// Shared types for the dice turn controller: dice colours, turn FSM states and
// the colour-to-step mapping used when a roll is accepted.
package dice_game_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10,
    BLUE  = 2'b11
  } color_t;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ARM         = 3'd1,
    WAIT_DICE   = 3'd2,
    MOVE        = 3'd3,
    WAIT_REMOVE = 3'd4,
    GAME_OVER   = 3'd5
  } turn_state_t;

  function automatic logic [1:0] color_to_steps(input color_t c);
    case (c)
      RED:     return 2'd1;
      GREEN:   return 2'd2;
      BLUE:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/dice_step_sequencer.sv
// Paces a move one square at a time: a STEP_CYCLES timer plus a count of
// squares still to go. step_pulse_o marks the cycle a square is taken.
module dice_step_sequencer #(
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [1:0] steps_i,
  input  logic       abort_i,
  output logic       step_pulse_o,
  output logic       done_o
);

  localparam int TW = $clog2(STEP_CYCLES);

  logic          active_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    remaining_q;

  assign step_pulse_o = active_q && (timer_q == TW'(STEP_CYCLES - 1));
  assign done_o       = step_pulse_o && (remaining_q == 2'd1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q    <= 1'b0;
      timer_q     <= '0;
      remaining_q <= 2'd0;
    end else if (abort_i) begin
      active_q    <= 1'b0;
      timer_q     <= '0;
      remaining_q <= 2'd0;
    end else if (load_i) begin
      active_q    <= 1'b1;
      timer_q     <= '0;
      remaining_q <= steps_i;
    end else if (active_q) begin
      if (step_pulse_o) begin
        timer_q     <= '0;
        remaining_q <= remaining_q - 2'd1;
        if (remaining_q == 2'd1) active_q <= 1'b0;
      end else begin
        timer_q <= timer_q + TW'(1);
      end
    end
  end

endmodule

// File: rtl/dice_turn_controller.sv
// Turn-order and board-movement controller fed by the dice colour detector.
// Optional WAIT_DICE timeout is compiled in with `DICE_TURN_TIMEOUT_EN.
module dice_turn_controller
  import dice_game_pkg::*;
#(
  parameter int NUM_PLAYERS    = 4,
  parameter int TRACK_LEN      = 16,
  parameter int STEP_CYCLES    = 25_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000,
  localparam int POS_W         = $clog2(TRACK_LEN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_game,
  input  logic [1:0]                   stable_color,
  input  logic                         result_ready,
  input  logic                         turn_end,
  input  logic                         current_state_white,
  output logic [1:0]                   cur_player,
  output logic [NUM_PLAYERS*POS_W-1:0] player_pos,
  output logic [1:0]                   move_steps,
  output logic                         step_pulse,
  output logic                         game_over,
  output logic [1:0]                   winner,
  output logic                         turn_skipped,
  output logic [2:0]                   state_dbg
);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 4 || STEP_CYCLES < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("dice_turn_controller: parameter out of range");
  end

  turn_state_t                  state_q, state_d;
  logic [1:0]                   cur_player_q, cur_player_d;
  logic [NUM_PLAYERS*POS_W-1:0] pos_q, pos_d;
  logic [1:0]                   move_steps_q, move_steps_d;
  logic                         remove_seen_q, remove_seen_d;
  logic                         step_pulse_q, step_pulse_d;

  logic             dice_valid;
  logic             seq_load, seq_abort, seq_step, seq_done;
  logic [POS_W-1:0] cur_pos;
  logic [1:0]       next_player;
  logic             to_expired;

  assign dice_valid  = result_ready && (color_t'(stable_color) != NONE);
  assign next_player = (cur_player_q == 2'(NUM_PLAYERS - 1)) ? 2'd0 : cur_player_q + 2'd1;

  always_comb begin
    cur_pos = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (cur_player_q == 2'(p)) cur_pos = pos_q[p*POS_W +: POS_W];
  end

  dice_step_sequencer #(.STEP_CYCLES(STEP_CYCLES)) u_seq (
    .clk          (clk),
    .reset        (reset),
    .load_i       (seq_load),
    .steps_i      (move_steps_d),
    .abort_i      (seq_abort),
    .step_pulse_o (seq_step),
    .done_o       (seq_done)
  );

`ifdef DICE_TURN_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYCLES);
  logic [TOW-1:0] to_cnt_q;
  logic           skipped_q;

  // A real roll in the final timeout cycle wins over the skip.
  assign to_expired = (state_q == WAIT_DICE) && !dice_valid &&
                      (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      skipped_q <= 1'b0;
    end else begin
      to_cnt_q  <= (state_q == WAIT_DICE && state_d == WAIT_DICE) ? to_cnt_q + TOW'(1) : '0;
      skipped_q <= to_expired;
    end
  end

  assign turn_skipped = skipped_q;
`else
  assign to_expired   = 1'b0;
  assign turn_skipped = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d       = state_q;
    cur_player_d  = cur_player_q;
    pos_d         = pos_q;
    move_steps_d  = move_steps_q;
    remove_seen_d = remove_seen_q;
    step_pulse_d  = 1'b0;
    seq_load      = 1'b0;
    seq_abort     = 1'b0;

    case (state_q)
      IDLE, GAME_OVER: begin
        if (start_game) begin
          state_d       = ARM;
          pos_d         = '0;
          cur_player_d  = 2'd0;
          remove_seen_d = 1'b0;
        end
      end
      ARM: begin
        if (current_state_white) state_d = WAIT_DICE;
      end
      WAIT_DICE: begin
        if (dice_valid) begin
          move_steps_d = color_to_steps(color_t'(stable_color));
          seq_load     = 1'b1;
          state_d      = MOVE;
        end else if (to_expired) begin
          cur_player_d = next_player;
          state_d      = ARM;
        end
      end
      MOVE: begin
        if (turn_end) remove_seen_d = 1'b1;
        if (seq_step) begin
          for (int p = 0; p < NUM_PLAYERS; p++)
            if (cur_player_q == 2'(p)) pos_d[p*POS_W +: POS_W] = cur_pos + POS_W'(1);
          step_pulse_d = 1'b1;
          // Landing on the goal ends the game; leftover steps are dropped.
          if (cur_pos == POS_W'(TRACK_LEN - 2)) begin
            seq_abort = 1'b1;
            state_d   = GAME_OVER;
          end else if (seq_done) begin
            state_d = WAIT_REMOVE;
          end
        end
      end
      WAIT_REMOVE: begin
        if (turn_end || remove_seen_q) begin
          remove_seen_d = 1'b0;
          cur_player_d  = next_player;
          state_d       = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_player_q  <= 2'd0;
      pos_q         <= '0;
      move_steps_q  <= 2'd0;
      remove_seen_q <= 1'b0;
      step_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_player_q  <= cur_player_d;
      pos_q         <= pos_d;
      move_steps_q  <= move_steps_d;
      remove_seen_q <= remove_seen_d;
      step_pulse_q  <= step_pulse_d;
    end
  end

  assign cur_player = cur_player_q;
  assign player_pos = pos_q;
  assign move_steps = move_steps_q;
  assign step_pulse = step_pulse_q;
  assign game_over  = (state_q == GAME_OVER);
  assign winner     = game_over ? cur_player_q : 2'd0;
  assign state_dbg  = state_q;

endmodule
